// File: rtl/score4_pkg.sv
// Shared Score 4 types and default board geometry.
package score4_pkg;

  localparam int DEF_COLS = 7;
  localparam int DEF_ROWS = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10
  } cell_t;

  typedef enum logic {
    IDLE = 1'b0,
    FALL = 1'b1
  } state_t;

endpackage

// File: rtl/board_state_column_cursor.sv
// One-hot column cursor that rotates with wrap-around.
module column_cursor #(
  parameter int COLS = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            left,
  input  logic            right,
  input  logic            en,
  output logic [COLS-1:0] play
);

  // rotate toward bit 0 on left, toward bit COLS-1 on right; both together cancel
  always_ff @(posedge clk) begin
    if (rst)
      play <= COLS'(1);
    else if (en && (left ^ right)) begin
      if (left)
        play <= {play[0], play[COLS-1:1]};
      else
        play <= {play[COLS-2:0], play[COLS-1]};
    end
  end

endmodule

// File: rtl/board_state.sv
// Score 4 game-state engine: board, cursor, turn, and animated gravity drop.
module board_state
  import score4_pkg::*;
#(
  parameter int COLS        = DEF_COLS,
  parameter int ROWS        = DEF_ROWS,
  parameter int STEP_CYCLES = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             left,
  input  logic                             right,
  input  logic                             drop,
  input  logic                             game_over,
  output logic [COLS-1:0][ROWS-1:0][1:0]   panel,
  output logic [COLS-1:0]                  play,
  output logic                             turn,
  output logic                             busy,
  output logic                             move_done,
  output logic                             col_full,
  output logic                             draw
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(ROWS + 1);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  // the piece currently in flight
  typedef struct packed {
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    cell_t         colour;
  } piece_t;

  state_t                 state, state_nxt;
  piece_t                 piece;
  logic [COLS-1:0][HW-1:0] height;
  logic [SW-1:0]          step_cnt;
  logic [CW-1:0]          cur_col;
  logic [RW-1:0]          tgt_row, nxt_row;
  logic                   wrap, start, reject, advance, land, all_full;
  cell_t                  colour;

  column_cursor #(.COLS(COLS)) u_cursor (
    .clk   (clk),
    .rst   (rst),
    .left  (left),
    .right (right),
    .en    (!game_over),
    .play  (play)
  );

  // one-hot cursor to column index (pre-move column, since play is registered)
  always_comb begin
    cur_col = '0;
    for (int i = 0; i < COLS; i++)
      if (play[i]) cur_col = CW'(i);
  end

  assign colour  = turn ? GREEN : RED;
  assign tgt_row = RW'(ROWS - 1) - RW'(height[piece.col]);
  assign nxt_row = piece.row + RW'(1);
  assign wrap    = (step_cnt == SW'(STEP_CYCLES - 1));

  // board is full when every column height has reached ROWS
  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < COLS; i++)
      if (height[i] != HW'(ROWS)) all_full = 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    reject    = 1'b0;
    advance   = 1'b0;
    land      = 1'b0;
    case (state)
      IDLE: begin
        if (drop && !game_over && !draw) begin
          if (height[cur_col] == HW'(ROWS)) reject = 1'b1;
          else begin
            start     = 1'b1;
            state_nxt = FALL;
          end
        end
      end
      FALL: begin
        if (wrap) begin
          if (piece.row == tgt_row) begin
            land      = 1'b1;
            state_nxt = IDLE;
          end else
            advance = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // board, heights, turn, step timer and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      panel     <= '0;
      height    <= '0;
      piece     <= '0;
      step_cnt  <= '0;
      turn      <= 1'b0;
      busy      <= 1'b0;
      move_done <= 1'b0;
      col_full  <= 1'b0;
      draw      <= 1'b0;
    end else begin
      move_done <= land;
      col_full  <= reject;
      // heights settle on the landing edge, so draw follows one cycle later
      draw      <= draw | all_full;
      if (start) begin
        piece.col          <= cur_col;
        piece.row          <= '0;
        piece.colour       <= colour;
        panel[cur_col][0]  <= colour;
        step_cnt           <= '0;
        busy               <= 1'b1;
      end else if (state == FALL) begin
        step_cnt <= wrap ? '0 : step_cnt + SW'(1);
      end
      if (advance) begin
        panel[piece.col][piece.row] <= EMPTY;
        panel[piece.col][nxt_row]   <= piece.colour;
        piece.row                   <= nxt_row;
      end
      if (land) begin
        height[piece.col] <= height[piece.col] + HW'(1);
        turn              <= ~turn;
        busy              <= 1'b0;
      end
    end
  end

endmodule
